// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared definitions for the nibble-serial adder slice: nibble width, FSM
//   state encoding and a helper that sizes the nibble counter.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for WIDTH/4 nibbles; never narrower than one bit so a
  // single-nibble adder still has a legal counter.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width / NIBBLE_W);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_adder_4.sv
// full_adder_4
//   4-bit ripple-carry adder built from four one-bit full adders.
// Ports:
//   a, b   : 4-bit addends
//   c_in   : carry into bit 0
//   sum    : 4-bit sum
//   c_out  : carry out of bit 3
module full_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;

  assign carry[0] = c_in;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder. Operands are accepted through a valid/ready
//   handshake, then fed one nibble per cycle (LSB nibble first) into a single
//   full_adder_4; the nibble carry is registered between cycles. The result
//   is presented through a valid/ready output handshake.
//   Optional macro NIBBLE_SERIAL_ADDER_OVF_EN adds a two's-complement
//   overflow output (ovf) registered alongside sum.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, c_in)
//   out_valid/out_ready : result handshake (sum, c_out[, ovf])
//   busy                : high while nibbles are being added
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(WIDTH);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh_reg;
  logic [WIDTH-1:0]   b_sh_reg;
  logic [WIDTH-1:0]   sum_sh_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               carry_reg;
  logic               c_out_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_co;
  logic [WIDTH-1:0]    sum_sh_next;
  logic                last_nib;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic a_msb_reg;
  logic b_msb_reg;
  logic ovf_reg;
`endif

  full_adder_4 u_fa (
    .a     (a_sh_reg[NIBBLE_W-1:0]),
    .b     (b_sh_reg[NIBBLE_W-1:0]),
    .c_in  (carry_reg),
    .sum   (nib_sum),
    .c_out (nib_co)
  );

  // New nibble enters from the top, so after the last cycle the nibbles
  // sit in their natural positions. A single-nibble adder has nothing to
  // shift down, hence the separate case.
  generate
    if (NIBBLES == 1) begin : g_one_nib
      assign sum_sh_next = nib_sum;
    end else begin : g_multi_nib
      assign sum_sh_next = {nib_sum, sum_sh_reg[WIDTH-1:NIBBLE_W]};
    end
  endgenerate

  assign last_nib = (cnt_reg == CNT_W'(NIBBLES - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = ADD;
      ADD:     if (last_nib)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      sum_reg    <= '0;
      carry_reg  <= 1'b0;
      c_out_reg  <= 1'b0;
      cnt_reg    <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= c_in;
            cnt_reg   <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
`endif
          end
        end
        ADD: begin
          a_sh_reg   <= a_sh_reg >> NIBBLE_W;
          b_sh_reg   <= b_sh_reg >> NIBBLE_W;
          sum_sh_reg <= sum_sh_next;
          carry_reg  <= nib_co;
          cnt_reg    <= cnt_reg + 1'b1;
          // Result registers change only here, so the previous result stays
          // visible through IDLE.
          if (last_nib) begin
            sum_reg   <= sum_sh_next;
            c_out_reg <= nib_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_reg   <= (a_msb_reg == b_msb_reg) &&
                         (sum_sh_next[WIDTH-1] != a_msb_reg);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == ADD);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//   Table-driven directed vectors, hand-written reset/backpressure sequences
//   and randomized transactions checked against an arithmetic reference.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           hold;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned addition, carry is bit W of the wide result.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    return r;
  endfunction

  // Reference overflow: signed result outside the representable range.
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
    int r;
    r = int'($signed(x)) + int'($signed(y)) + int'(ci);
    return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tc,
                         input int hold, input bit noise, input logic [W-1:0] es,
                         input logic ec, input string tag);
    int lat;
    int bcnt;
    chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    a        = ta;
    b        = tb_op;
    c_in     = tc;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!out_valid && lat < 20) begin
      bcnt += int'(busy);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom());
        b        = W'($urandom());
        c_in     = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    $display("txn %s: a=%h b=%h cin=%0d -> sum=%h c_out=%0d lat=%0d", tag, ta, tb_op, tc,
             sum, c_out, lat);
    chk({tag, ".latency"}, 64'(lat), 64'd4);
    chk({tag, ".busy_cycles"}, 64'(bcnt), 64'd4);
    chk({tag, ".sum"}, 64'(sum), 64'(es));
    chk({tag, ".c_out"}, 64'(c_out), 64'(ec));
    chk({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk({tag, ".ovf"}, 64'(ovf), 64'(ref_ovf(ta, tb_op, tc)));
`endif
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom());
        b        = W'($urandom());
      end
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_sum"}, 64'(sum), 64'(es));
      chk({tag, ".hold_cout"}, 64'(c_out), 64'(ec));
      chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, ".idle_sum_held"}, 64'(sum), 64'(es));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0]   r;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    tbl[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, hold: 0, exp_sum: 16'h5555, exp_cout: 1'b0};
    tbl[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, hold: 0, exp_sum: 16'h0000, exp_cout: 1'b1};
    tbl[2] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, hold: 5, exp_sum: 16'hFFFF, exp_cout: 1'b1};
    tbl[3] = '{a: 16'h8001, b: 16'h7FFF, cin: 1'b0, hold: 2, exp_sum: 16'h0000, exp_cout: 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.sum", 64'(sum), 64'd0);
    chk("reset.c_out", 64'(c_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, back-to-back (the 5-cycle backpressure case is tbl[2]).
    for (int i = 0; i < 4; i++)
      run_txn(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].hold, 1'b0,
              tbl[i].exp_sum, tbl[i].exp_cout, $sformatf("tbl%0d", i));

    // out_ready with nothing to deliver must not disturb IDLE.
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_ready.out_valid", 64'(out_valid), 64'd0);
    chk("idle_ready.in_ready", 64'(in_ready), 64'd1);

    // Leave a nonzero result visible, then reset in the middle of ADD.
    r = ref_add(16'h1357, 16'h2468, 1'b0);
    run_txn(16'h1357, 16'h2468, 1'b0, 0, 1'b0, r[W-1:0], r[W], "pre_reset");
    a        = 16'h5555;
    b        = 16'h5555;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.busy", 64'(busy), 64'd0);
    chk("midreset.in_ready", 64'(in_ready), 64'd1);
    chk("midreset.out_valid", 64'(out_valid), 64'd0);
    chk("midreset.sum", 64'(sum), 64'd0);
    chk("midreset.c_out", 64'(c_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postreset.no_valid", 64'(out_valid), 64'd0);
    end
    run_txn(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0, 16'h1000, 1'b0, "after_reset");

    // Randomized traffic with input noise during ADD/DONE.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom());
      rb = W'($urandom());
      rc = 1'($urandom_range(0, 1));
      if (i == 0) begin
        ra = 16'h7FFF;
        rb = 16'h0000;
        rc = 1'b1;
      end
      r = ref_add(ra, rb, rc);
      run_txn(ra, rb, rc, int'($urandom_range(0, 3)), 1'b1, r[W-1:0], r[W],
              $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that sits directly upstream of the codebase's existing 4-bit ripple adder (full_adder_4) and drives it.
- Accepts an operand pair through a valid/ready handshake.
- Feeds the 4-bit adder one nibble per cycle, least-significant first, and registers the nibble carry between cycles.
- Presents the full sum and carry-out through a valid/ready output handshake.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and ≥ 4; anything else is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  A+B+c_in, low WIDTH bits
- c_out  output  1  carry out of bit WIDTH-1
- busy  output  1  high in ADD state

Behaviour:
- Interface: one clock, clk; reset asynchronous active-low, rst_n.
- Reset (async assert, sync release), all values 0 except in_ready:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, c_out=0.
  - Operand shift registers, carry register and nibble counter cleared.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b into shift registers; carry_reg=c_in; cnt=0; go to ADD.
  - in_valid low: stay in IDLE.
- ADD (WIDTH/4 cycles):
  - Each cycle, full_adder_4 receives a_sh[3:0], b_sh[3:0], carry_reg.
  - Its 4-bit sum shifts into sum_sh from the top (sum_sh = {nib, sum_sh[WIDTH-1:4]}).
  - Its carry-out loads carry_reg; a_sh and b_sh shift right 4; cnt++.
  - in_ready=0; inputs are ignored.
  - When cnt==WIDTH/4-1: transfer to DONE on that edge, with final sum and c_out=carry-out registered.
- DONE:
  - out_valid=1; sum and c_out held stable.
  - On out_ready: out_valid drops, go to IDLE.
  - No simultaneous accept: in_ready=0 in DONE.
- Latency: accepting edge at T0 → out_valid high after edge T0+WIDTH/4.
  - WIDTH=16: 4 cycles.
  - Minimum initiation interval: WIDTH/4+2 cycles.
- Ordering: sum/c_out registers update only on the ADD→DONE edge and otherwise hold their previous result, including in IDLE.
- Arithmetic: unsigned, modulo 2^WIDTH; c_out is bit WIDTH of the full result. Carry propagates across nibbles only through carry_reg, never combinationally.
- in_valid in ADD/DONE: ignored, never latched. Upstream must hold operands until in_ready.
- Reset mid-ADD or mid-DONE: abort immediately to the reset values; the partial result is discarded; no out_valid pulse.
- out_ready high while out_valid=0: no effect.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- With the macro defined:
  - Extra output port ovf (1 bit): two's-complement overflow, computed as (a_msb==b_msb) && (sum[WIDTH-1]!=a_msb).
  - a_msb and b_msb are registered at accept.
  - ovf is registered with sum, reset to 0, and valid with out_valid.
- Without the macro: no ovf port, no MSB capture registers. All other behaviour is identical.

Decomposition:
- Shared package adder_pkg:
  - NIBBLE_W=4 constant.
  - State typedef enum {IDLE, ADD, DONE}, 2 bits.
  - Function for the counter width, clog2(WIDTH/4) with minimum 1.
- One sub-module: reuse the existing full_adder_4 as the single per-nibble datapath instance. No other hierarchy.

Test Plan (WIDTH=16 unless noted):
- a=0x1234, b=0x4321, c_in=0 → sum=0x5555, c_out=0; out_valid exactly 4 cycles after the accepting edge; busy high for those 4 cycles.
- a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1 (carry ripples through all 4 nibbles via carry_reg); then a=0xFFFF, b=0xFFFF, c_in=1 → sum=0xFFFF, c_out=1.
- Backpressure: result ready, out_ready=0 for 5 cycles → out_valid, sum, c_out stable and in_ready=0 throughout; out_ready=1 → IDLE next cycle; back-to-back operand accepted with correct result.
- Reset mid-ADD: assert rst_n=0 after 2 ADD cycles → outputs go to reset values asynchronously; after release, a=0x0F0F, b=0x00F1 → sum=0x1000, c_out=0 with no stale output.
- Input noise: toggle in_valid with random operands during ADD/DONE → result matches only the originally accepted pair.
- With NIBBLE_SERIAL_ADDER_OVF_EN, WIDTH=8: 0x7F+0x01 → sum=0x80, ovf=1, c_out=0; 0x80+0x80 → sum=0x00, ovf=1, c_out=1; 0x10+0x20 → ovf=0.
